// File: rtl/whackamole_game.sv
// Whack-a-mole controller: synchronized start/buttons, LFSR mole pick, gap/window timing, scoring.
// Optional build macro WHACKAMOLE_SPEEDUP_EN: each hit shortens the lit window, floored at a quarter.
module whackamole_game #(
  parameter int NUM_MOLES     = 8,
  parameter int WINDOW_CYCLES = 1000,
  parameter int GAP_CYCLES    = 100,
  parameter int MAX_MISSES    = 3,
  parameter int SCORE_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole_out,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           miss_cnt,
  output logic                 hit,
  output logic                 miss,
  output logic                 game_over
);

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  localparam logic [15:0]        GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [2:0]         MISS_LIMIT = 3'(MAX_MISSES);
  localparam logic [3:0]         MOLES      = 4'(NUM_MOLES);

  state_t               state;
  logic [15:0]          cnt;
  logic [7:0]           lfsr;

  logic [NUM_MOLES-1:0] btn_s1, btn_s2, btn_prev, btn_edge;
  logic                 start_s1, start_s2, start_prev, start_edge;
  logic [1:0]           start_vld;
  logic                 start_armed;

  // NOTE: every flop uses non-blocking assignment and the async active-low reset,
  // so all registers update together and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1      <= '0;
      btn_s2      <= '0;
      btn_prev    <= '0;
      btn_edge    <= '0;
      start_s1    <= 1'b0;
      start_s2    <= 1'b0;
      start_prev  <= 1'b0;
      start_edge  <= 1'b0;
      start_vld   <= 2'b00;
      start_armed <= 1'b0;
    end else begin
      btn_s1      <= btn;
      btn_s2      <= btn_s1;
      btn_prev    <= btn_s2;
      btn_edge    <= btn_s2 & ~btn_prev;
      start_s1    <= start;
      start_s2    <= start_s1;
      start_prev  <= start_s2;
      start_vld   <= {start_vld[0], 1'b1};
      // A start level held through reset must be seen low once before a rise can count.
      start_armed <= start_armed | (start_vld[1] & ~start_s2);
      start_edge  <= start_armed & start_s2 & ~start_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  logic [3:0]           raw_idx, mole_idx;
  logic [NUM_MOLES-1:0] mole_onehot;

  assign raw_idx     = {1'b0, lfsr[2:0]};
  assign mole_idx    = (raw_idx >= MOLES) ? raw_idx - MOLES : raw_idx;
  assign mole_onehot = {{(NUM_MOLES-1){1'b0}}, 1'b1} << mole_idx;

  logic       lit_edge, wrong_edge, game_start, score_hit, window_done;
  logic [2:0] miss_next;

  assign lit_edge   = |(btn_edge & mole_out);
  assign wrong_edge = |(btn_edge & ~mole_out);
  assign game_start = start_edge && ((state == IDLE) || (state == OVER));
  assign score_hit  = (state == UP) && lit_edge && !wrong_edge;
  assign miss_next  = miss_cnt + 3'd1;

  logic [15:0] win_len;

`ifdef WHACKAMOLE_SPEEDUP_EN
  localparam logic [15:0] WIN_FULL  = 16'(WINDOW_CYCLES);
  localparam logic [15:0] WIN_STEP  = 16'(WINDOW_CYCLES / 16);
  localparam logic [15:0] WIN_FLOOR = 16'(WINDOW_CYCLES / 4);

  // win_len never drops below WIN_FLOOR >= WIN_STEP, so the subtraction cannot wrap.
  logic [15:0] win_short;
  assign win_short = (win_len - WIN_STEP < WIN_FLOOR) ? WIN_FLOOR : win_len - WIN_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len <= WIN_FULL;
    end else if (game_start) begin
      win_len <= WIN_FULL;
    end else if (score_hit) begin
      win_len <= win_short;
    end
  end
`else
  assign win_len = 16'(WINDOW_CYCLES);
`endif

  assign window_done = (cnt == win_len - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mole_out  <= '0;
      score     <= '0;
      miss_cnt  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state     <= GAP;
            cnt       <= '0;
            score     <= '0;
            miss_cnt  <= '0;
            game_over <= 1'b0;
            mole_out  <= '0;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state    <= UP;
            cnt      <= '0;
            mole_out <= mole_onehot;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        UP: begin
          // A wrong button beats a same-cycle correct one; a correct edge beats the timeout.
          if (wrong_edge || (!lit_edge && window_done)) begin
            miss     <= 1'b1;
            miss_cnt <= miss_next;
            mole_out <= '0;
            cnt      <= '0;
            if (miss_next >= MISS_LIMIT) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (lit_edge) begin
            hit      <= 1'b1;
            score    <= (score == SCORE_MAX) ? score : score + 1'b1;
            mole_out <= '0;
            cnt      <= '0;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whackamole_game.sv
// Self-checking bench for whackamole_game: table of rounds, pulse scoreboard, reset corner cases.
module tb_whackamole_game;

  localparam int NM  = 6;
  localparam int WIN = 16;
  localparam int GAP = 4;
  localparam int MM  = 3;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NM-1:0] btn = '0;
  logic [NM-1:0] mole_out;
  logic [SW-1:0] score;
  logic [2:0]    miss_cnt;
  logic          hit, miss, game_over;

  whackamole_game #(
    .NUM_MOLES(NM), .WINDOW_CYCLES(WIN), .GAP_CYCLES(GAP), .MAX_MISSES(MM), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .mole_out(mole_out),
    .score(score), .miss_cnt(miss_cnt), .hit(hit), .miss(miss), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, one step per clock.
  logic [7:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef enum {A_LIT, A_WRONG, A_BOTH, A_LAST, A_NONE} act_e;

  typedef struct {
    act_e          act;
    logic          poke;
    logic          exp_hit;
    logic [SW-1:0] exp_score;
    logic [2:0]    exp_mc;
    logic          exp_over;
  } rec_t;

  typedef struct {
    logic          hit;
    logic          miss;
    logic [SW-1:0] score;
    logic [2:0]    mc;
    logic          over;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && (hit || miss)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b at cycle %0d, none expected", hit, miss, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_hit", hit, mon_e.hit);
        check("pulse_miss", miss, mon_e.miss);
        check("pulse_score", score, mon_e.score);
        check("pulse_miss_cnt", miss_cnt, mon_e.mc);
        check("pulse_game_over", game_over, mon_e.over);
        check("pulse_mole_dark", mole_out, 0);
      end
    end
  end

  rec_t vec[13];
  int   next_up_cyc = 0;
  int   win_m = WIN;
  int   lit_idx = 0;

  task automatic wait_cycles_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press_start(output int act_cyc);
    start = 1'b1;
    act_cyc = cyc + 4;
    @(negedge clk);
    start = 1'b0;
    next_up_cyc = act_cyc + GAP;
    win_m = WIN;
  endtask

  task automatic wait_mole();
    int  idx;
    bit  seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mole_out != '0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL mole_wait: no mole lit within bound, expected at cycle %0d", next_up_cyc);
    end else begin
      idx = int'(lfsr_prev[2:0]);
      if (idx >= NM) idx = idx - NM;
      lit_idx = idx;
      check("mole_light_cycle", cyc, next_up_cyc);
      check("mole_onehot", mole_out, 32'(1) << idx);
    end
  endtask

  task automatic play(input rec_t r);
    int t0, act_cyc;
    logic [NM-1:0] lit_b, wrong_b;
    exp_t e;
    wait_mole();
    t0 = cyc;
    lit_b   = NM'(1) << lit_idx;
    wrong_b = NM'(1) << ((lit_idx + 1) % NM);
    case (r.act)
      A_LAST:  begin wait_cycles_to(t0 + win_m - 4); act_cyc = t0 + win_m; end
      A_NONE:  act_cyc = t0 + win_m;
      default: act_cyc = t0 + 4;
    endcase
    e = '{r.exp_hit, !r.exp_hit, r.exp_score, r.exp_mc, r.exp_over, act_cyc};
    sb_q.push_back(e);
    if (r.act != A_NONE) begin
      case (r.act)
        A_WRONG: btn = wrong_b;
        A_BOTH:  btn = lit_b | wrong_b;
        default: btn = lit_b;
      endcase
      @(negedge clk);
      btn = '0;
    end
`ifdef WHACKAMOLE_SPEEDUP_EN
    if (r.exp_hit) win_m = (win_m - WIN / 16 < WIN / 4) ? WIN / 4 : win_m - WIN / 16;
`endif
    next_up_cyc = act_cyc + GAP;
    wait_cycles_to(act_cyc);
    if (r.poke) begin
      btn = '1;
      start = 1'b1;
      @(negedge clk);
      btn = '0;
      start = 1'b0;
    end
    wait_cycles_to(act_cyc + 1);
  endtask

  int sc;

  initial begin
    vec[0]  = '{A_LIT,   1'b0, 1'b1, 2'd1, 3'd0, 1'b0};
    vec[1]  = '{A_LIT,   1'b1, 1'b1, 2'd2, 3'd0, 1'b0};
    vec[2]  = '{A_BOTH,  1'b0, 1'b0, 2'd2, 3'd1, 1'b0};
    vec[3]  = '{A_LIT,   1'b0, 1'b1, 2'd3, 3'd1, 1'b0};
    vec[4]  = '{A_LIT,   1'b0, 1'b1, 2'd3, 3'd1, 1'b0};
    vec[5]  = '{A_WRONG, 1'b0, 1'b0, 2'd3, 3'd2, 1'b0};
    vec[6]  = '{A_LAST,  1'b0, 1'b1, 2'd3, 3'd2, 1'b0};
    vec[7]  = '{A_NONE,  1'b0, 1'b0, 2'd3, 3'd3, 1'b1};
    vec[8]  = '{A_NONE,  1'b1, 1'b0, 2'd0, 3'd1, 1'b0};
    vec[9]  = '{A_NONE,  1'b0, 1'b0, 2'd0, 3'd2, 1'b0};
    vec[10] = '{A_NONE,  1'b0, 1'b0, 2'd0, 3'd3, 1'b1};
    vec[11] = '{A_LIT,   1'b0, 1'b1, 2'd1, 3'd0, 1'b0};
    vec[12] = '{A_LIT,   1'b0, 1'b1, 2'd2, 3'd0, 1'b0};

    // Reset state, then idle with no start.
    #1;
    check("rst_mole_out", mole_out, 0);
    check("rst_score", score, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_game_over", game_over, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_mole_out", mole_out, 0);

    // Game 1: hits, saturation, both-pressed, wrong, last-cycle hit, timeout to OVER.
    press_start(sc);
    for (int i = 0; i < 8; i++) play(vec[i]);

    // OVER holds its results and ignores buttons.
    btn = '1;
    @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    check("over_game_over", game_over, 1);
    check("over_score_held", score, 3);
    check("over_miss_cnt_held", miss_cnt, 3);
    check("over_mole_dark", mole_out, 0);

    // Restart from OVER and let every window time out.
    press_start(sc);
    wait_cycles_to(sc - 1);
    check("restart_before_edge_over", game_over, 1);
    wait_cycles_to(sc);
    check("restart_game_over", game_over, 0);
    check("restart_score", score, 0);
    check("restart_miss_cnt", miss_cnt, 0);
    for (int i = 8; i < 11; i++) play(vec[i]);
    check("timeout_game_over", game_over, 1);
    check("timeout_score", score, 0);

    // Reset in the middle of UP with score 2, start held through release.
    press_start(sc);
    for (int i = 11; i < 13; i++) play(vec[i]);
    wait_mole();
    check("pre_reset_score", score, 2);
    start = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mole_out", mole_out, 0);
    check("midrst_score", score, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    check("midrst_hit", hit, 0);
    check("midrst_miss", miss, 0);
    check("midrst_game_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    btn = '1;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (30) @(negedge clk);
    check("held_start_ignored_mole", mole_out, 0);
    check("held_start_ignored_score", score, 0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    press_start(sc);
    wait_mole();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
